// File: rtl/vga_grid_scanner.sv
// VGA 640x480 timing generator that maps active pixels onto a cell grid,
// reads each cell's colour from an external register bank and emits registered rgb/sync.
module vga_grid_scanner #(
    parameter int unsigned BIT_ADDR  = 4,
    parameter int unsigned BIT_DATO  = 3,
    parameter int unsigned GRID_COLS = 4,
    parameter int unsigned GRID_ROWS = 4,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_en,
    output logic [BIT_ADDR-1:0] addrR,
    input  logic [BIT_DATO-1:0] datOutR,
    output logic [BIT_DATO-1:0] rgb,
    output logic                hsync,
    output logic                vsync,
    output logic                frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CELL_W  = H_ACTIVE / GRID_COLS;
    localparam int unsigned CELL_H  = V_ACTIVE / GRID_ROWS;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned X_W     = $clog2(CELL_W + 1);
    localparam int unsigned Y_W     = $clog2(CELL_H + 1);
    // col/row step one past the last cell at the end of the active span
    localparam int unsigned COL_W   = $clog2(GRID_COLS + 1);
    localparam int unsigned ROW_W   = $clog2(GRID_ROWS + 1);

    logic [H_W-1:0]      h_cnt_q, h_cnt_d;
    logic [V_W-1:0]      v_cnt_q, v_cnt_d;
    logic [X_W-1:0]      x_in_q, x_in_d;
    logic [Y_W-1:0]      y_in_q, y_in_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic                act1_q, act1_d;
    logic                hs1_q, hs1_d;
    logic                vs1_q, vs1_d;
    logic                fs1_q, fs1_d;
    logic [BIT_DATO-1:0] rgb_q, rgb_d;
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                frame_start_q, frame_start_d;

    logic h_wrap, v_wrap, h_act, v_act, active, hs, vs;

    assign h_wrap = (h_cnt_q == H_W'(H_TOTAL - 1));
    assign v_wrap = (v_cnt_q == V_W'(V_TOTAL - 1));
    assign h_act  = (h_cnt_q < H_W'(H_ACTIVE));
    assign v_act  = (v_cnt_q < V_W'(V_ACTIVE));
    assign active = h_act && v_act;
    assign hs     = !((h_cnt_q >= H_W'(H_ACTIVE + H_FP)) &&
                      (h_cnt_q <  H_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs     = !((v_cnt_q >= V_W'(V_ACTIVE + V_FP)) &&
                      (v_cnt_q <  V_W'(V_ACTIVE + V_FP + V_SYNC)));

    // Counters, cell tracking and the two output pipeline stages
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        x_in_d        = x_in_q;
        y_in_d        = y_in_q;
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        act1_d        = act1_q;
        hs1_d         = hs1_q;
        vs1_d         = vs1_q;
        fs1_d         = fs1_q;
        rgb_d         = rgb_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;

        if (pix_en) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + H_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + V_W'(1);
            end

            if (h_wrap) begin
                x_in_d = '0;
                col_d  = '0;
            end else if (h_act) begin
                if (x_in_q == X_W'(CELL_W - 1)) begin
                    x_in_d = '0;
                    col_d  = col_q + COL_W'(1);
                end else begin
                    x_in_d = x_in_q + X_W'(1);
                end
            end

            if (h_wrap) begin
                if (v_wrap) begin
                    y_in_d = '0;
                    row_d  = '0;
                end else if (v_act) begin
                    if (y_in_q == Y_W'(CELL_H - 1)) begin
                        y_in_d = '0;
                        row_d  = row_q + ROW_W'(1);
                    end else begin
                        y_in_d = y_in_q + Y_W'(1);
                    end
                end
            end

            // Address only moves on active pixels so blanking keeps the last cell
            if (active) begin
                addr_d = BIT_ADDR'(row_q) * BIT_ADDR'(GRID_COLS) + BIT_ADDR'(col_q);
            end
            act1_d = active;
            hs1_d  = hs;
            vs1_d  = vs;
            fs1_d  = (h_cnt_q == '0) && (v_cnt_q == '0);

            rgb_d         = act1_q ? datOutR : '0;
            hsync_d       = hs1_q;
            vsync_d       = vs1_q;
            frame_start_d = fs1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_in_q        <= '0;
            y_in_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            addr_q        <= '0;
            act1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            fs1_q         <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_in_q        <= x_in_d;
            y_in_q        <= y_in_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            act1_q        <= act1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            fs1_q         <= fs1_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign addrR       = addr_q;
    assign rgb         = rgb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_grid_scanner.sv
// Bench for vga_grid_scanner: scaled-down timing, pixel-index reference model and literal spot checks.
module tb_vga_grid_scanner;

    localparam int unsigned BA  = 4;
    localparam int unsigned BD  = 3;
    localparam int unsigned GC  = 4;
    localparam int unsigned GR  = 4;
    localparam int unsigned HA  = 16;
    localparam int unsigned HFP = 2;
    localparam int unsigned HS  = 3;
    localparam int unsigned HBP = 3;
    localparam int unsigned VA  = 8;
    localparam int unsigned VFP = 2;
    localparam int unsigned VS  = 2;
    localparam int unsigned VBP = 1;
    localparam int HT    = 24;
    localparam int VT    = 13;
    localparam int CW    = 4;
    localparam int CH    = 2;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_en;
    logic [BA-1:0] addrR;
    logic [BD-1:0] datOutR;
    logic [BD-1:0] rgb;
    logic          hsync;
    logic          vsync;
    logic          frame_start;
    logic [BD-1:0] bank [0:15];

    always #5 clk = ~clk;
    assign datOutR = bank[addrR];

    vga_grid_scanner #(
        .BIT_ADDR(BA), .BIT_DATO(BD), .GRID_COLS(GC), .GRID_ROWS(GR),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .addrR(addrR), .datOutR(datOutR),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    // Pixel i (0-based, counted in pix_en edges since reset) sits at (i%HT, (i/HT)%VT)
    function automatic int px_h(input int i); return i % HT; endfunction
    function automatic int px_v(input int i); return (i / HT) % VT; endfunction
    function automatic bit px_active(input int i);
        return (px_h(i) < HA) && (px_v(i) < VA);
    endfunction
    function automatic int px_cell(input int i);
        return (px_v(i) / CH) * GC + px_h(i) / CW;
    endfunction
    function automatic bit px_hs(input int i);
        return !((px_h(i) >= HA + HFP) && (px_h(i) < HA + HFP + HS));
    endfunction
    function automatic bit px_vs(input int i);
        return !((px_v(i) >= VA + VFP) && (px_v(i) < VA + VFP + VS));
    endfunction

    int            p;
    logic [BD-1:0] e_rgb;
    logic          e_hs, e_vs, e_fs;
    logic [BA-1:0] e_addr;
    int            out_h, out_v;
    bit            out_valid;

    // Reference model: p pixels consumed; output shows pixel p-2, address holds last active cell
    always @(posedge clk) begin
        if (rst) begin
            p <= 0; e_rgb <= '0; e_hs <= 1'b1; e_vs <= 1'b1; e_fs <= 1'b0;
            e_addr <= '0; out_valid <= 1'b0; out_h <= 0; out_v <= 0;
        end else if (pix_en) begin
            p <= p + 1;
            if (px_active(p)) e_addr <= BA'(px_cell(p));
            if (p >= 1) begin
                e_rgb     <= px_active(p - 1) ? bank[px_cell(p - 1)] : '0;
                e_hs      <= px_hs(p - 1);
                e_vs      <= px_vs(p - 1);
                e_fs      <= ((p - 1) % FRAME) == 0;
                out_h     <= px_h(p - 1);
                out_v     <= px_v(p - 1);
                out_valid <= 1'b1;
            end else begin
                e_rgb <= '0; e_hs <= 1'b1; e_vs <= 1'b1; e_fs <= 1'b0;
            end
        end else begin
            e_fs <= 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive pix_en, take one clock, then compare every output against the model
    task automatic tick(input bit en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("rgb", int'(rgb), int'(e_rgb));
            chk("hsync", int'(hsync), int'(e_hs));
            chk("vsync", int'(vsync), int'(e_vs));
            chk("frame_start", int'(frame_start), int'(e_fs));
            chk("addrR", int'(addrR), int'(e_addr));
        end
    endtask

    task automatic wait_out(input int h, input int v, input int budget);
        int n = 0;
        while (!(out_valid && out_h == h && out_v == v)) begin
            if (n >= budget) begin
                tests++;
                fails++;
                $display("FAIL wait_out(%0d,%0d): pixel not reached within %0d cycles", h, v, budget);
                return;
            end
            tick(1'b1);
            n++;
        end
    endtask

    initial begin
        int clk_n, first_clk, period, hs_low, vs_low, phase, n;

        rst = 1'b1;
        pix_en = 1'b1;
        for (int i = 0; i < 16; i++) bank[i] = BD'($urandom_range(0, 7));

        // Reset held three clocks with pix_en active
        tick(1'b1);
        chk_en = 1'b1;
        tick(1'b1);
        tick(1'b1);
        chk("reset rgb", int'(rgb), 0);
        chk("reset hsync", int'(hsync), 1);
        chk("reset vsync", int'(vsync), 1);
        chk("reset addrR", int'(addrR), 0);
        chk("reset frame_start", int'(frame_start), 0);

        // Address map with bank[i] = i % 8
        for (int i = 0; i < 16; i++) bank[i] = BD'(i % 8);
        rst = 1'b0;
        wait_out(0, 0, 4);
        chk("map (0,0)", int'(rgb), 0);
        chk("map (0,0) frame_start", int'(frame_start), 1);
        wait_out(CW, 0, FRAME);
        chk("map (CW,0)", int'(rgb), 1);
        wait_out(HA - 1, 0, FRAME);
        chk("map (HA-1,0)", int'(rgb), 3);
        wait_out(0, CH, FRAME);
        chk("map (0,CH)", int'(rgb), 4);
        wait_out(HA - 1, VA - 1, FRAME);
        chk("map (HA-1,VA-1)", int'(rgb), 7);

        // Blanking forces black even with every cell white
        for (int i = 0; i < 16; i++) bank[i] = 3'b111;
        wait_out(0, VA, FRAME);
        chk("blank (0,VA)", int'(rgb), 0);
        wait_out(HT - 1, VT - 1, FRAME);
        chk("blank (HT-1,VT-1)", int'(rgb), 0);
        wait_out(0, 0, FRAME);
        chk("white (0,0)", int'(rgb), 7);
        wait_out(HA, 1, FRAME);
        chk("blank (HA,1)", int'(rgb), 0);

        // Half-rate pix_en: frame period and sync widths
        for (int i = 0; i < 16; i++) bank[i] = BD'($urandom_range(0, 7));
        clk_n = 0; first_clk = 0; period = 0; hs_low = 0; vs_low = 0; phase = 0;
        for (int k = 0; k < 6 * FRAME + 10 && phase < 2; k++) begin
            bit en;
            en = (k % 2) == 1;
            tick(en);
            clk_n++;
            if (en && frame_start) begin
                if (phase == 0) begin
                    phase = 1;
                    first_clk = clk_n;
                end else begin
                    period = clk_n - first_clk;
                    phase = 2;
                end
            end
            if (phase == 1 && en) begin
                hs_low += int'(!hsync);
                vs_low += int'(!vsync);
            end
        end
        chk("frame_start period clk", period, 2 * FRAME);
        chk("hsync low pixels per frame", hs_low, VT * int'(HS));
        chk("vsync low pixels per frame", vs_low, HT * int'(VS));

        // Random pix_en and bank writes, with a 10-clock stall mid-run
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) bank[$urandom_range(0, 15)] = BD'($urandom_range(0, 7));
            if (k == 1000) begin
                for (int s = 0; s < 10; s++) begin
                    bank[$urandom_range(0, 15)] = BD'($urandom_range(0, 7));
                    tick(1'b0);
                end
            end
            tick($urandom_range(0, 9) < 6);
        end

        // Reset with the counters mid-frame
        wait_out(HA / 2 - 2, VA / 2, 2 * FRAME);
        bank[0] = 3'd5;
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        n = 0;
        do begin
            tick(1'b1);
            n++;
        end while (!frame_start && n < 10);
        chk("pix_en from reset to frame_start", n, 2);
        chk("first pixel after reset", int'(rgb), 5);
        tick(1'b1);
        tick(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
